io_ld_router: RTL and testbench
===============================

Name: io_ld_router

Overview:
- Parametrised successor of the load-data mux and I/O output router.
- Registers the load path with one-cycle latency and a valid strobe.
- Extracts byte or halfword lanes, with sign or zero extension; flags unmapped and misaligned loads.
- Synchronises raw switch and button inputs, and drives a configurable number of 7-segment digits from registered output buffers.
- Sits between the LSU address decode and the board I/O pins.

Parameters:
- SW_W, 10, switch input width (1..32)
- BTN_W, 4, button input width (1..32)
- NUM_HEX, 8, number of 7-segment digits (4 or 8); each 32-bit hex word packs 4 digits
- DEBOUNCE_CYCLES, 16, stable cycles required before a button change is accepted (only with IO_DEBOUNCE_EN)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high
- i_ld_req  in  1  load request this cycle
- i_ld_addr  in  32  load byte address
- i_ld_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- i_ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- f_dmem_valid  in  1  address decodes to DMEM
- f_io_valid  in  1  address decodes to I/O
- b_dmem_data  in  32  DMEM read word (combinational, same cycle as request)
- b_io_ledr  in  32  red LED buffer
- b_io_ledg  in  32  green LED buffer
- b_io_hex  in  NUM_HEX*8  packed digit bytes; digit k = bits [8k+6:8k]
- b_io_lcd  in  32  LCD buffer
- i_io_sw  in  SW_W  raw switches (asynchronous)
- i_io_btn  in  BTN_W  raw buttons (asynchronous)
- o_ld_valid  out  1  load result valid
- o_ld_data  out  32  extended load data
- o_ld_err  out  1  unmapped, misaligned or reserved-size load
- o_io_ledr  out  32  registered red LEDs
- o_io_ledg  out  32  registered green LEDs
- o_io_hex  out  NUM_HEX*7  registered digit segments; digit k = bits [7k+6:7k]
- o_io_lcd  out  32  registered LCD
- o_io_sw_sync  out  SW_W  synchronised switches
- o_io_btn_sync  out  BTN_W  synchronised (and optionally debounced) buttons

Behaviour:
- Reset values:
  - o_ld_valid, o_ld_data, o_ld_err = 0
  - o_io_ledr, o_io_ledg, o_io_lcd = 0
  - every o_io_hex digit = 7'h7F (blank)
  - sync flops, o_io_sw_sync, o_io_btn_sync = 0
- Latency and throughput:
  - A request in cycle N gives o_ld_valid=1 in cycle N+1.
  - Back-to-back requests give throughput of 1 per cycle.
  - No request gives o_ld_valid=0; o_ld_data holds its last value.
- Source select, sampled in cycle N:
  - f_dmem_valid has priority over f_io_valid.
  - I/O map, by addr[31:16] and addr[15:12]:
    - 0x1000 & 0: ledr
    - 0x1000 & 1: ledg
    - 0x1000 & 2: hex word 0
    - 0x1000 & 3: hex word 1 (only when NUM_HEX=8)
    - 0x1000 & 4: lcd
    - 0x1001 & 0: o_io_sw_sync, zero-extended
    - 0x1001 & 1: o_io_btn_sync, zero-extended
  - Any other I/O address, or neither flag set: data 0 and err=1.
  - Hex words read back from the b_io_hex bytes.
- Alignment and size:
  - Byte: lane addr[1:0]; bits [7:0] taken from word bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - Half: lane addr[1]; addr[0]=1 is an error.
  - Word: addr[1:0]≠0 is an error.
  - Size 11 is an error.
  - On any error, o_ld_data=0.
  - Extension per i_ld_unsigned.
- Input sync:
  - 2-flop synchroniser per bit.
  - o_io_sw_sync and o_io_btn_sync equal the second flop.
  - A raw change is visible 2 cycles later.
- Outputs: o_io_* register b_io_* every cycle, so a buffer change appears 1 cycle later.
- Reset mid-operation:
  - A request accepted in the cycle before reset is dropped; o_ld_valid=0 in the cycle after reset asserts.
  - A request coincident with reset is ignored.

Optional Feature:
- Macro: IO_DEBOUNCE_EN.
- Defined:
  - Each button bit has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets to 0 whenever the synchronised bit equals its debounced output.
  - Otherwise it increments.
  - On reaching DEBOUNCE_CYCLES, the debounced output takes the new value and the counter clears.
  - o_io_btn_sync and button loads return the debounced value.
  - Reset clears all counters and outputs.
- Undefined: no counters; o_io_btn_sync is the 2-flop output directly.

Test Plan:
- Byte/half/word loads:
  - DMEM word 0x8081_7F02, f_dmem_valid=1, lb at addr[1:0]=2, signed → o_ld_data=0xFFFF_FF81, valid next cycle.
  - lbu at the same address → 0x0000_0081.
  - lh at addr[1:0]=2 → 0xFFFF_8081.
- I/O map:
  - Load word 0x1000_1000 with b_io_ledg=0x0000_00A5 → 0x0000_00A5.
  - Load word 0x1001_0000 with i_io_sw=10'h3FF held ≥2 cycles → 0x0000_03FF.
  - Load word 0x1000_7000 → data 0, err=1.
- Misaligned and reserved:
  - lw at 0x1000_0002 → err=1, data 0.
  - lh at addr[0]=1 → err=1.
  - size=11 → err=1.
- Pipelining and priority:
  - Requests on 3 consecutive cycles → valid high for 3 consecutive cycles with matching data.
  - Both flags set → DMEM data returned.
- Reset and hex:
  - After reset, o_io_hex is all 7'h7F.
  - Set b_io_hex byte 0 = 0x40 → digit 0 = 7'h40 one cycle later.
  - Assert reset with a request in flight → o_ld_valid=0 in the next cycle.
- Debounce (IO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16):
  - Button toggles for 5 cycles then returns → no change on o_io_btn_sync.
  - Button held 20 cycles → o_io_btn_sync changes 2+16 cycles after the edge.

Source files
------------

// File: rtl/io_ld_router.sv
// Load-data router and board I/O front end: registered load path with lane extraction,
// input synchronisers and registered output buffers. Define IO_DEBOUNCE_EN to debounce buttons.
module io_ld_router #(
   parameter int SW_W            = 10,
   parameter int BTN_W           = 4,
   parameter int NUM_HEX         = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_ld_req,
   input  logic [31:0]          i_ld_addr,
   input  logic [1:0]           i_ld_size,
   input  logic                 i_ld_unsigned,
   input  logic                 f_dmem_valid,
   input  logic                 f_io_valid,
   input  logic [31:0]          b_dmem_data,
   input  logic [31:0]          b_io_ledr,
   input  logic [31:0]          b_io_ledg,
   input  logic [NUM_HEX*8-1:0] b_io_hex,
   input  logic [31:0]          b_io_lcd,
   input  logic [SW_W-1:0]      i_io_sw,
   input  logic [BTN_W-1:0]     i_io_btn,
   output logic                 o_ld_valid,
   output logic [31:0]          o_ld_data,
   output logic                 o_ld_err,
   output logic [31:0]          o_io_ledr,
   output logic [31:0]          o_io_ledg,
   output logic [NUM_HEX*7-1:0] o_io_hex,
   output logic [31:0]          o_io_lcd,
   output logic [SW_W-1:0]      o_io_sw_sync,
   output logic [BTN_W-1:0]     o_io_btn_sync
);

   logic [SW_W-1:0]      r_swMeta, r_swSync;
   logic [BTN_W-1:0]     r_btnMeta, r_btnSync;
   logic [BTN_W-1:0]     w_btnOut;
   logic [63:0]          w_hexWords;
   logic [31:0]          w_srcWord;
   logic                 w_srcErr;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [31:0]          w_extData;
   logic                 w_alignErr;
   logic                 r_ldValid, r_ldErr;
   logic [31:0]          r_ldData;
   logic [31:0]          r_ledr, r_ledg, r_lcd;
   logic [NUM_HEX*7-1:0] r_hex;
   logic [NUM_HEX-1:0]   w_unusedHexBit7;
   logic                 w_unusedBits;

   assign w_hexWords = 64'(b_io_hex);

   // DMEM wins over I/O; anything that decodes nowhere is an error returning zero.
   always_comb begin
      w_srcWord = '0;
      w_srcErr  = 1'b1;
      if (f_dmem_valid) begin
         w_srcWord = b_dmem_data;
         w_srcErr  = 1'b0;
      end else if (f_io_valid) begin
         if (i_ld_addr[31:16] == 16'h1000) begin
            case (i_ld_addr[15:12])
               4'h0: begin w_srcWord = b_io_ledr;         w_srcErr = 1'b0; end
               4'h1: begin w_srcWord = b_io_ledg;         w_srcErr = 1'b0; end
               4'h2: begin w_srcWord = w_hexWords[31:0];  w_srcErr = 1'b0; end
               4'h3: begin
                  if (NUM_HEX == 8) begin
                     w_srcWord = w_hexWords[63:32];
                     w_srcErr  = 1'b0;
                  end
               end
               4'h4: begin w_srcWord = b_io_lcd;          w_srcErr = 1'b0; end
               default: ;
            endcase
         end else if (i_ld_addr[31:16] == 16'h1001) begin
            case (i_ld_addr[15:12])
               4'h0: begin w_srcWord = 32'(r_swSync); w_srcErr = 1'b0; end
               4'h1: begin w_srcWord = 32'(w_btnOut); w_srcErr = 1'b0; end
               default: ;
            endcase
         end
      end
   end

   assign w_byte = 8'(w_srcWord >> {i_ld_addr[1:0], 3'b000});
   assign w_half = 16'(w_srcWord >> {i_ld_addr[1], 4'b0000});

   always_comb begin
      w_extData  = '0;
      w_alignErr = 1'b0;
      case (i_ld_size)
         2'b00: w_extData = i_ld_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01: begin
            w_extData  = i_ld_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            w_alignErr = i_ld_addr[0];
         end
         2'b10: begin
            w_extData  = w_srcWord;
            w_alignErr = (i_ld_addr[1:0] != 2'b00);
         end
         default: w_alignErr = 1'b1;
      endcase
   end

   // Result and error hold their last values when no request arrives.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ldValid <= 1'b0;
         r_ldData  <= '0;
         r_ldErr   <= 1'b0;
      end else begin
         r_ldValid <= i_ld_req;
         if (i_ld_req) begin
            r_ldErr  <= w_srcErr | w_alignErr;
            r_ldData <= (w_srcErr | w_alignErr) ? 32'h0 : w_extData;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_swMeta  <= '0;
         r_swSync  <= '0;
         r_btnMeta <= '0;
         r_btnSync <= '0;
         r_ledr    <= '0;
         r_ledg    <= '0;
         r_lcd     <= '0;
         r_hex     <= {NUM_HEX{7'h7F}};
      end else begin
         r_swMeta  <= i_io_sw;
         r_swSync  <= r_swMeta;
         r_btnMeta <= i_io_btn;
         r_btnSync <= r_btnMeta;
         r_ledr    <= b_io_ledr;
         r_ledg    <= b_io_ledg;
         r_lcd     <= b_io_lcd;
         for (int k = 0; k < NUM_HEX; k++) begin
            r_hex[7*k +: 7] <= b_io_hex[8*k +: 7];
         end
      end
   end

`ifdef IO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CNT_W-1:0] r_dbCnt [BTN_W];
   logic [BTN_W-1:0] r_btnDeb;

   // A button is accepted only after it differs from the debounced value for the full window.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_btnDeb <= '0;
         for (int i = 0; i < BTN_W; i++) r_dbCnt[i] <= '0;
      end else begin
         for (int i = 0; i < BTN_W; i++) begin
            if (r_btnSync[i] == r_btnDeb[i]) begin
               r_dbCnt[i] <= '0;
            end else if (r_dbCnt[i] + CNT_W'(1) == CNT_W'(DEBOUNCE_CYCLES)) begin
               r_btnDeb[i] <= r_btnSync[i];
               r_dbCnt[i]  <= '0;
            end else begin
               r_dbCnt[i] <= r_dbCnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign w_btnOut = r_btnDeb;
`else
   logic w_unusedDebounce;
   assign w_unusedDebounce = (DEBOUNCE_CYCLES > 0);
   assign w_btnOut         = r_btnSync;
`endif

   always_comb begin
      w_unusedHexBit7 = '0;
      for (int k = 0; k < NUM_HEX; k++) w_unusedHexBit7[k] = b_io_hex[8*k+7];
   end
   assign w_unusedBits = ^{i_ld_addr[11:2], w_unusedHexBit7};

   assign o_ld_valid    = r_ldValid;
   assign o_ld_data     = r_ldData;
   assign o_ld_err      = r_ldErr;
   assign o_io_ledr     = r_ledr;
   assign o_io_ledg     = r_ledg;
   assign o_io_hex      = r_hex;
   assign o_io_lcd      = r_lcd;
   assign o_io_sw_sync  = r_swSync;
   assign o_io_btn_sync = w_btnOut;

endmodule

// File: tb/tb_io_ld_router.sv
// Scoreboard bench for io_ld_router: directed loads push expected results, a negedge monitor checks them.
module tb_io_ld_router;

   localparam int SW_W    = 10;
   localparam int BTN_W   = 4;
   localparam int NUM_HEX = 8;

   logic                 i_clk = 1'b0;
   logic                 i_reset;
   logic                 i_ld_req;
   logic [31:0]          i_ld_addr;
   logic [1:0]           i_ld_size;
   logic                 i_ld_unsigned;
   logic                 f_dmem_valid;
   logic                 f_io_valid;
   logic [31:0]          b_dmem_data;
   logic [31:0]          b_io_ledr;
   logic [31:0]          b_io_ledg;
   logic [NUM_HEX*8-1:0] b_io_hex;
   logic [31:0]          b_io_lcd;
   logic [SW_W-1:0]      i_io_sw;
   logic [BTN_W-1:0]     i_io_btn;
   logic                 o_ld_valid;
   logic [31:0]          o_ld_data;
   logic                 o_ld_err;
   logic [31:0]          o_io_ledr;
   logic [31:0]          o_io_ledg;
   logic [NUM_HEX*7-1:0] o_io_hex;
   logic [31:0]          o_io_lcd;
   logic [SW_W-1:0]      o_io_sw_sync;
   logic [BTN_W-1:0]     o_io_btn_sync;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        err;
   } expT;

   expT expQueue[$];
   int  checkCount = 0;
   int  failCount  = 0;

   io_ld_router #(.SW_W(SW_W), .BTN_W(BTN_W), .NUM_HEX(NUM_HEX), .DEBOUNCE_CYCLES(16)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr),
      .i_ld_size(i_ld_size), .i_ld_unsigned(i_ld_unsigned), .f_dmem_valid(f_dmem_valid),
      .f_io_valid(f_io_valid), .b_dmem_data(b_dmem_data), .b_io_ledr(b_io_ledr),
      .b_io_ledg(b_io_ledg), .b_io_hex(b_io_hex), .b_io_lcd(b_io_lcd), .i_io_sw(i_io_sw),
      .i_io_btn(i_io_btn), .o_ld_valid(o_ld_valid), .o_ld_data(o_ld_data), .o_ld_err(o_ld_err),
      .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg), .o_io_hex(o_io_hex), .o_io_lcd(o_io_lcd),
      .o_io_sw_sync(o_io_sw_sync), .o_io_btn_sync(o_io_btn_sync)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drives one load request for a cycle and records the response the monitor should see next cycle.
   task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic dmem, input logic io,
                                input logic [31:0] dmemData, input logic [31:0] expData, input logic expErr);
      expT e;
      i_ld_req      = 1'b1;
      i_ld_addr     = addr;
      i_ld_size     = size;
      i_ld_unsigned = uns;
      f_dmem_valid  = dmem;
      f_io_valid    = io;
      b_dmem_data   = dmemData;
      e.name = name;
      e.data = expData;
      e.err  = expErr;
      expQueue.push_back(e);
      @(posedge i_clk);
      #1;
   endtask

   task automatic idleCycle();
      i_ld_req = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   // The monitor pops one expected entry per valid result, independent of the stimulus flow.
   initial begin
      expT e;
      forever begin
         @(negedge i_clk);
         if (o_ld_valid === 1'b1) begin
            if (expQueue.size() == 0) begin
               checkCount++;
               failCount++;
               $display("[TB] FAIL unexpected_valid: got data %h, expected no result", o_ld_data);
            end else begin
               e = expQueue.pop_front();
               checkOutput(e.name, {31'h0, o_ld_err, o_ld_data}, {31'h0, e.err, e.data});
            end
         end
      end
   end

   initial begin
      logic sawGlitch;
      i_reset = 1'b1;
      i_ld_req = 1'b0; i_ld_addr = '0; i_ld_size = '0; i_ld_unsigned = 1'b0;
      f_dmem_valid = 1'b0; f_io_valid = 1'b0; b_dmem_data = '0;
      b_io_ledr = '0; b_io_ledg = 32'h0000_00A5; b_io_hex = '0; b_io_lcd = '0;
      i_io_sw = '0; i_io_btn = '0;
      sawGlitch = 1'b0;

      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("reset_ld_valid", 64'(o_ld_valid), 64'd0);
      checkOutput("reset_ld_data", 64'(o_ld_data), 64'd0);
      checkOutput("reset_hex_blank", 64'(o_io_hex), 64'h00FF_FFFF_FFFF_FFFF);
      checkOutput("reset_ledg", 64'(o_io_ledg), 64'd0);

      @(posedge i_clk); #1;
      i_reset = 1'b0;
      b_io_hex = 64'h0000_0000_0000_FF40;
      b_io_ledr = 32'hDEAD_BEEF;
      i_io_sw = 10'h3FF;
      @(negedge i_clk);
      checkOutput("hex_before_edge", 64'(o_io_hex[6:0]), 64'h7F);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      checkOutput("hex_digit0", 64'(o_io_hex[6:0]), 64'h40);
      checkOutput("hex_digit1_bit7_dropped", 64'(o_io_hex[13:7]), 64'h7F);
      checkOutput("ledr_one_cycle", 64'(o_io_ledr), 64'hDEAD_BEEF);
      checkOutput("sw_sync_one_edge", 64'(o_io_sw_sync), 64'h000);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      checkOutput("sw_sync_two_edges", 64'(o_io_sw_sync), 64'h3FF);
      @(posedge i_clk); #1;

`ifdef IO_DEBOUNCE_EN
      for (int i = 0; i < 5; i++) begin
         i_io_btn[0] = ~i_io_btn[0];
         @(posedge i_clk); #1;
      end
      i_io_btn[0] = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge i_clk);
         if (o_io_btn_sync[0] !== 1'b0) sawGlitch = 1'b1;
      end
      checkOutput("debounce_rejects_bounce", 64'(sawGlitch), 64'd0);
      @(posedge i_clk); #1;
      i_io_btn[0] = 1'b1;
      repeat (17) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("debounce_before_window", 64'(o_io_btn_sync[0]), 64'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("debounce_after_window", 64'(o_io_btn_sync[0]), 64'd1);
      @(posedge i_clk); #1;
      i_io_btn[0] = 1'b0;
      repeat (20) @(posedge i_clk);
      #1;
`endif

      applyStimulus("lb_signed", 32'h0000_0002, 2'b00, 1'b0, 1'b1, 1'b0, 32'h8081_7F02, 32'hFFFF_FF81, 1'b0);
      idleCycle();
      applyStimulus("lbu", 32'h0000_0002, 2'b00, 1'b1, 1'b1, 1'b0, 32'h8081_7F02, 32'h0000_0081, 1'b0);
      idleCycle();
      applyStimulus("lh_signed", 32'h0000_0002, 2'b01, 1'b0, 1'b1, 1'b0, 32'h8081_7F02, 32'hFFFF_8081, 1'b0);
      idleCycle();
      applyStimulus("io_ledg", 32'h1000_1000, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_00A5, 1'b0);
      idleCycle();
      applyStimulus("io_sw", 32'h1001_0000, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_03FF, 1'b0);
      idleCycle();
      applyStimulus("io_unmapped", 32'h1000_7000, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
      idleCycle();
      applyStimulus("lw_misaligned", 32'h1000_0002, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
      idleCycle();
      applyStimulus("lh_misaligned", 32'h0000_0001, 2'b01, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      idleCycle();
      applyStimulus("size_reserved", 32'h0000_0000, 2'b11, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 1'b1);
      idleCycle();
      applyStimulus("lb_ledr_byte3", 32'h1000_0003, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFDE, 1'b0);
      idleCycle();

      b_io_hex = 64'h1122_3344_5566_7788;
      applyStimulus("io_hex_word1", 32'h1000_3000, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1122_3344, 1'b0);
      applyStimulus("io_hex_word0_lbu", 32'h1000_2001, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0077, 1'b0);
      idleCycle();

      i_io_btn = 4'b1010;
      repeat (25) idleCycle();
      applyStimulus("io_btn", 32'h1001_1000, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_000A, 1'b0);
      idleCycle();

      applyStimulus("b2b_word", 32'h0000_0000, 2'b10, 1'b0, 1'b1, 1'b0, 32'h1111_1111, 32'h1111_1111, 1'b0);
      applyStimulus("b2b_lbu", 32'h0000_0001, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0000_AB00, 32'h0000_00AB, 1'b0);
      applyStimulus("b2b_lhu", 32'h0000_0000, 2'b01, 1'b1, 1'b1, 1'b0, 32'h1234_F00D, 32'h0000_F00D, 1'b0);
      idleCycle();
      applyStimulus("neither_flag", 32'h0000_0000, 2'b10, 1'b0, 1'b0, 1'b0, 32'h5555_5555, 32'h0, 1'b1);
      applyStimulus("dmem_priority", 32'h1000_1000, 2'b10, 1'b0, 1'b1, 1'b1, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0);
      idleCycle();
      @(negedge i_clk);
      checkOutput("idle_valid_low", 64'(o_ld_valid), 64'd0);
      checkOutput("idle_data_holds", 64'(o_ld_data), 64'hCAFE_BABE);
      @(posedge i_clk); #1;

      applyStimulus("inflight_before_reset", 32'h0000_0000, 2'b10, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0);
      i_ld_req = 1'b0;
      i_reset  = 1'b1;
      @(posedge i_clk); #1;
      @(negedge i_clk);
      checkOutput("reset_flushes_valid", 64'(o_ld_valid), 64'd0);
      i_ld_req = 1'b1;
      @(posedge i_clk); #1;
      i_ld_req = 1'b0;
      i_reset  = 1'b0;
      @(negedge i_clk);
      checkOutput("req_with_reset_ignored", 64'(o_ld_valid), 64'd0);
      repeat (3) idleCycle();
      checkOutput("scoreboard_drained", 64'(expQueue.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
